// File: rtl/dstack_ctl.sv
// dstack_ctl: eForth data stack sequencer, TOS/NOS in registers, deeper cells spilled to a sync-read RAM.
// Defining DSTACK_PICK_EN turns opcode 0 (NOP) into PICK n.
module dstack_ctl #(
    parameter int DSZ   = 32,
    parameter int DEPTH = 64,
    parameter int SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [2:0]     op,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] nos,
    output logic [SSZ:0]   depth,
    output logic [1:0]     err,
    input  logic           err_clr,
    output logic           m_we,
    output logic [SSZ-1:0] m_addr,
    output logic [DSZ-1:0] m_wd,
    input  logic [DSZ-1:0] m_rd
);
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_DROP = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_OVER = 3'd5;
    localparam logic [2:0] OP_ROT  = 3'd6;
    localparam logic [2:0] OP_REPL = 3'd7;
    localparam logic [SSZ:0] ONE   = (SSZ+1)'(1);
    localparam logic [SSZ:0] TWO   = (SSZ+1)'(2);
    localparam logic [SSZ:0] THREE = (SSZ+1)'(3);
    localparam logic [SSZ:0] FULL  = (SSZ+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
`ifdef DSTACK_PICK_EN
        PFIL,
`endif
        ROT2
    } state_t;

    state_t         state, state_n;
    logic [DSZ-1:0] tos_n, nos_n, push_v;
    logic [SSZ:0]   depth_n;
    logic [1:0]     err_n;
    logic           acc, full, push;
`ifdef DSTACK_PICK_EN
    logic [SSZ:0]   n;
    assign n = vi[SSZ:0];
`endif

    assign op_ready = state == IDLE;
    assign acc      = op_valid && op_ready;
    assign full     = depth == FULL;

    always_comb begin
        state_n = state;
        tos_n   = tos;
        nos_n   = nos;
        depth_n = depth;
        err_n   = err_clr ? 2'b00 : err;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wd    = '0;
        push    = 1'b0;
        push_v  = '0;
        case (state)
            IDLE: if (acc) begin
                case (op)
                    OP_PUSH: if (full) err_n[1] = 1'b1; else begin push = 1'b1; push_v = vi; end
                    OP_DUP:  if (full) err_n[1] = 1'b1; else begin push = 1'b1; push_v = tos; end
                    OP_OVER: if (depth < TWO) err_n[0] = 1'b1;
                             else if (full) err_n[1] = 1'b1;
                             else begin push = 1'b1; push_v = nos; end
                    OP_DROP: if (depth == '0) err_n[0] = 1'b1;
                             else begin
                                 tos_n   = nos;
                                 depth_n = depth - ONE;
                                 if (depth >= THREE) begin
                                     m_addr  = SSZ'(depth - THREE);
                                     state_n = FILL;
                                 end else
                                     nos_n = '0;
                             end
                    OP_SWAP: if (depth < TWO) err_n[0] = 1'b1; else begin tos_n = nos; nos_n = tos; end
                    OP_ROT:  if (depth < THREE) err_n[0] = 1'b1;
                             else begin
                                 m_addr  = SSZ'(depth - THREE);
                                 state_n = ROT2;
                             end
                    OP_REPL: if (depth == '0) err_n[0] = 1'b1; else tos_n = vi;
                    default: begin
`ifdef DSTACK_PICK_EN
                        if (n >= depth) err_n[0] = 1'b1;
                        else if (full) err_n[1] = 1'b1;
                        else if (n < TWO) begin
                            push   = 1'b1;
                            push_v = n == '0 ? tos : nos;
                        end else begin
                            m_addr  = SSZ'(depth - ONE - n);
                            state_n = PFIL;
                        end
`endif
                    end
                endcase
            end
            FILL: begin
                nos_n   = m_rd;
                state_n = IDLE;
            end
`ifdef DSTACK_PICK_EN
            PFIL: begin
                push    = 1'b1;
                push_v  = m_rd;
                state_n = IDLE;
            end
`endif
            ROT2: begin
                m_we    = 1'b1;
                m_addr  = SSZ'(depth - THREE);
                m_wd    = nos;
                tos_n   = m_rd;
                nos_n   = tos;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // every push shifts NOS down into RAM once the register pair is occupied
        if (push) begin
            tos_n   = push_v;
            nos_n   = tos;
            depth_n = depth + ONE;
            if (depth >= TWO) begin
                m_we   = 1'b1;
                m_addr = SSZ'(depth - TWO);
                m_wd   = nos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            tos   <= '0;
            nos   <= '0;
            depth <= '0;
            err   <= '0;
        end else begin
            state <= state_n;
            tos   <= tos_n;
            nos   <= nos_n;
            depth <= depth_n;
            err   <= err_n;
        end
endmodule
